// File: rtl/riscv_pkg.sv
// Shared fetch-stage encodings, instruction constants and state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCSRC_W = 2;

    localparam logic [PCSRC_W-1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_BR   = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JALR = 2'b10;

    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        TRAP = 2'b11
    } fetch_state_t;

    // Word alignment check for fetch targets.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC candidate selection: target adders, pc_src mux and misalign detect.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]    pc,
    input  logic [PCSRC_W-1:0] pc_src,
    input  logic [XLEN-1:0]    imm_ext,
    input  logic [XLEN-1:0]    jalr_target,
    output logic [XLEN-1:0]    target_c,
    output logic               misalign_c
);

    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_aligned;

    assign seq_target   = pc + XLEN'(4);
    assign br_target    = pc + imm_ext;
    assign jalr_aligned = jalr_target & ~XLEN'(1);

    // Reserved encoding falls through to sequential.
    always_comb begin
        target_c = seq_target;
        case (pc_src)
            PCSRC_BR:   target_c = br_target;
            PCSRC_JALR: target_c = jalr_aligned;
            default:    target_c = seq_target;
        endcase
        misalign_c = is_misaligned(target_c);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and retire counter feeding the instruction memory.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned IMEM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [1:0]  pc_src_i,
    input  logic [31:0] imm_ext_i,
    input  logic [31:0] jalr_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        halt_o,
    output logic        oob_o,
    output logic        misalign_o,
    output logic [31:0] bad_addr_o,
    output logic [31:0] instret_o
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instret_q;
    logic            valid_q;
    logic            halt_q;

    logic [XLEN-1:0] target_c;
    logic            misalign_c;
    logic [XLEN-1:0] pc_next_c;
    logic            is_ebreak_c;

    pc_next_sel u_next_sel (
        .pc          (pc_q),
        .pc_src      (pc_src_i),
        .imm_ext     (imm_ext_i),
        .jalr_target (jalr_target_i),
        .target_c    (target_c),
        .misalign_c  (misalign_c)
    );

    assign is_ebreak_c = (instr_i == INSTR_EBREAK);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q;
    logic [XLEN-1:0] bad_addr_q;

    assign pc_next_c  = target_c;
    assign misalign_o = misalign_q;
    assign bad_addr_o = bad_addr_q;
`else
    // Without the trap, misaligned targets are silently word-aligned.
    assign pc_next_c  = misalign_c ? {target_c[XLEN-1:2], 2'b00} : target_c;
    assign misalign_o = 1'b0;
    assign bad_addr_o = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
            valid_q   <= 1'b0;
            halt_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (!stall_i) begin
                        instret_q <= instret_q + XLEN'(1);
                        if (is_ebreak_c) begin
                            state_q <= HALT;
                            halt_q  <= 1'b1;
                            valid_q <= 1'b0;
                        end
`ifdef FETCH_MISALIGN_TRAP_EN
                        else if (misalign_c) begin
                            state_q    <= TRAP;
                            pc_q       <= TRAP_VECTOR;
                            bad_addr_q <= target_c;
                            misalign_q <= 1'b1;
                            valid_q    <= 1'b0;
                        end
`endif
                        else begin
                            pc_q <= pc_next_c;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                TRAP: begin
                    // Hold the handler address for its first fetch.
                    state_q <= RUN;
                    pc_q    <= TRAP_VECTOR;
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + XLEN'(4);
    assign instr_o       = valid_q ? instr_i : INSTR_NOP;
    assign instr_valid_o = valid_q;
    assign halt_o        = halt_q;
    assign instret_o     = instret_q;
    assign oob_o         = {1'b0, pc_q} >= (33'(IMEM_WORDS) << 2);

endmodule
